// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the CDB arbiter slice: bus widths, the
// idle ROB tag, requester count and the per-cycle operating mode decode.
package cdb_arbiter_pkg;

  localparam int ROB_WIDTH   = 5;
  localparam int DATA_WIDTH  = 32;
  localparam int CDB_REQ_NUM = 3;

  localparam logic [ROB_WIDTH-1:0]  ZERO_ROB  = '0;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
  localparam logic                  TRUE      = 1'b1;
  localparam logic                  FALSE     = 1'b0;

  // What the arbiter does at the next edge; flush dominates stall.
  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_STALL = 2'd1,
    MODE_FLUSH = 2'd2
  } cdb_mode_e;

  function automatic cdb_mode_e cdb_mode(input logic ena, input logic flush);
    if (flush) return MODE_FLUSH;
    if (!ena)  return MODE_STALL;
    return MODE_RUN;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. The request vector is duplicated and
// shifted so the slot after the previous winner lands at bit 0; the lowest
// set bit then wins and is mapped back to its real slot index.
module rr_arbiter #(
  parameter  int N     = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] w_start;
  logic [2*N-1:0]   w_shifted;
  logic [N-1:0]     w_rot;
  int               w_pos;

  // Rotate requests so bit 0 is the slot right after the last grant.
  always_comb begin
    w_start   = (last >= IDX_W'(N - 1)) ? '0 : last + IDX_W'(1);
    w_shifted = {req, req} >> w_start;
    w_rot     = w_shifted[N-1:0];
  end

  // Lowest rotated bit wins; descending scan leaves the lowest one last.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path can
    // leave one unassigned and infer a latch.
    grant_idx = '0;
    any       = 1'b0;
    w_pos     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_pos = int'(w_start) + k;
        if (w_pos >= N) w_pos = w_pos - N;
        grant_idx = IDX_W'(w_pos);
        any       = 1'b1;
      end
    end
    grant_onehot = any ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Shares the ALU-side common data bus between several result producers.
// Each requester owns a one-entry holding slot; one filled slot per cycle is
// picked round-robin and driven onto a registered CDB. Flush drops every
// buffered result, stall freezes slots and idles the bus.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_REQ_NUM,
  parameter int ROB_W   = ROB_WIDTH,
  parameter int DATA_W  = DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      in_flush,
  input  logic [NUM_REQ-1:0]        in_req_valid,
  input  logic [NUM_REQ*ROB_W-1:0]  in_req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] in_req_value,
  input  logic [NUM_REQ-1:0]        in_req_isjump,
  input  logic [NUM_REQ*DATA_W-1:0] in_req_jump_addr,
  output logic [NUM_REQ-1:0]        out_req_ready,
  output logic [ROB_W-1:0]          out_cdb_rob_tag,
  output logic [DATA_W-1:0]         out_cdb_value,
  output logic                      out_cdb_isjump,
  output logic [DATA_W-1:0]         out_cdb_jump_addr
);

  localparam int IDX_W = $clog2(NUM_REQ);

  cdb_mode_e           w_mode;
  logic [NUM_REQ-1:0]  w_accept;
  logic [NUM_REQ-1:0]  w_grant_onehot;
  logic [IDX_W-1:0]    w_grant_idx;
  logic                w_any;

  logic [NUM_REQ-1:0]  r_full;
  logic [IDX_W-1:0]    r_last;
  logic [ROB_W-1:0]    r_tag       [NUM_REQ];
  logic [DATA_W-1:0]   r_value     [NUM_REQ];
  logic [DATA_W-1:0]   r_jump_addr [NUM_REQ];
  logic [NUM_REQ-1:0]  r_isjump;

  logic [ROB_W-1:0]    r_cdb_tag;
  logic [DATA_W-1:0]   r_cdb_value;
  logic                r_cdb_isjump;
  logic [DATA_W-1:0]   r_cdb_jump_addr;

  assign w_mode = cdb_mode(ena, in_flush);

  // Ready ignores the same-cycle grant, so a draining slot is never refilled
  // at the edge it drains.
  assign out_req_ready = (w_mode == MODE_RUN) ? ~r_full : '0;

  // A zero tag completes the handshake but is dropped instead of stored.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_accept[i] = in_req_valid[i] && out_req_ready[i] &&
                    (in_req_tag[i*ROB_W +: ROB_W] != ROB_W'(ZERO_ROB));
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req          (r_full),
    .last         (r_last),
    .grant_onehot (w_grant_onehot),
    .grant_idx    (w_grant_idx),
    .any          (w_any)
  );

  // Slot occupancy and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    if (rst) begin
      r_full <= '0;
      r_last <= IDX_W'(NUM_REQ - 1);
    end else begin
      unique case (w_mode)
        MODE_FLUSH: r_full <= '0;
        MODE_RUN: begin
          r_full <= (r_full & ~w_grant_onehot) | w_accept;
          if (w_any) r_last <= w_grant_idx;
        end
        default: ;
      endcase
    end
  end

  // Capture the payload of every accepted request.
  // NOTE: payload storage has no reset; r_full qualifies it, so stale
  // contents are never broadcast.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_accept[i]) begin
        r_tag[i]       <= in_req_tag[i*ROB_W +: ROB_W];
        r_value[i]     <= in_req_value[i*DATA_W +: DATA_W];
        r_isjump[i]    <= in_req_isjump[i];
        r_jump_addr[i] <= in_req_jump_addr[i*DATA_W +: DATA_W];
      end
    end
  end

  // Registered CDB: granted payload when running, otherwise an idle bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cdb_tag       <= '0;
      r_cdb_value     <= '0;
      r_cdb_isjump    <= FALSE;
      r_cdb_jump_addr <= '0;
    end else if (w_mode == MODE_RUN && w_any) begin
      r_cdb_tag       <= r_tag[w_grant_idx];
      r_cdb_value     <= r_value[w_grant_idx];
      r_cdb_isjump    <= r_isjump[w_grant_idx];
      r_cdb_jump_addr <= r_jump_addr[w_grant_idx];
    end else begin
      r_cdb_tag       <= ROB_W'(ZERO_ROB);
      r_cdb_value     <= DATA_W'(ZERO_DATA);
      r_cdb_isjump    <= FALSE;
      r_cdb_jump_addr <= DATA_W'(ZERO_DATA);
    end
  end

  assign out_cdb_rob_tag   = r_cdb_tag;
  assign out_cdb_value     = r_cdb_value;
  assign out_cdb_isjump    = r_cdb_isjump;
  assign out_cdb_jump_addr = r_cdb_jump_addr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by a
// randomized phase, all compared against a slot-level reference model.
module tb_cdb_arbiter;

  localparam int N  = 3;
  localparam int RW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst, ena, in_flush;
  logic [N-1:0]    in_req_valid, in_req_isjump;
  logic [N*RW-1:0] in_req_tag;
  logic [N*DW-1:0] in_req_value, in_req_jump_addr;
  logic [N-1:0]    out_req_ready;
  logic [RW-1:0]   out_cdb_rob_tag;
  logic [DW-1:0]   out_cdb_value, out_cdb_jump_addr;
  logic            out_cdb_isjump;

  int checks   = 0;
  int failures = 0;

  // Reference model: slot contents, pointer and expected bus.
  bit          m_full [N];
  logic [RW-1:0] m_tag [N];
  logic [DW-1:0] m_val [N];
  logic [DW-1:0] m_jad [N];
  bit          m_isj [N];
  int          m_last;
  logic [RW-1:0] e_tag;
  logic [DW-1:0] e_val, e_jad;
  logic          e_isj;
  bit            e_chk_payload;

  cdb_arbiter #(.NUM_REQ(N), .ROB_W(RW), .DATA_W(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .ena               (ena),
    .in_flush          (in_flush),
    .in_req_valid      (in_req_valid),
    .in_req_tag        (in_req_tag),
    .in_req_value      (in_req_value),
    .in_req_isjump     (in_req_isjump),
    .in_req_jump_addr  (in_req_jump_addr),
    .out_req_ready     (out_req_ready),
    .out_cdb_rob_tag   (out_cdb_rob_tag),
    .out_cdb_value     (out_cdb_value),
    .out_cdb_isjump    (out_cdb_isjump),
    .out_cdb_jump_addr (out_cdb_jump_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [RW-1:0] t,
                         input logic [DW-1:0] val, input logic j, input logic [DW-1:0] ja);
    in_req_valid[i]             = v;
    in_req_tag[i*RW +: RW]      = t;
    in_req_value[i*DW +: DW]    = val;
    in_req_isjump[i]            = j;
    in_req_jump_addr[i*DW +: DW] = ja;
  endtask

  task automatic clear_reqs();
    in_req_valid     = '0;
    in_req_tag       = '0;
    in_req_value     = '0;
    in_req_isjump    = '0;
    in_req_jump_addr = '0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_full[i] = 0;
    m_last = N - 1;
    e_tag = '0; e_val = '0; e_isj = 1'b0; e_jad = '0;
    e_chk_payload = 1;
  endtask

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = !m_full[i] && ena && !in_flush;
    return r;
  endfunction

  // Apply one rising edge to the model using the inputs present at that edge.
  task automatic model_edge();
    bit pre [N];
    int g;
    if (in_flush) begin
      for (int i = 0; i < N; i++) m_full[i] = 0;
      e_tag = '0; e_val = '0; e_isj = 1'b0; e_jad = '0;
      e_chk_payload = 1;
    end else if (!ena) begin
      e_tag = '0;
      e_chk_payload = 0;
    end else begin
      pre = m_full;
      g = -1;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_last + 1 + k) % N;
        if (g < 0 && pre[idx]) g = idx;
      end
      if (g >= 0) begin
        e_tag = m_tag[g]; e_val = m_val[g]; e_isj = m_isj[g]; e_jad = m_jad[g];
        m_full[g] = 0;
        m_last = g;
      end else begin
        e_tag = '0; e_val = '0; e_isj = 1'b0; e_jad = '0;
      end
      e_chk_payload = 1;
      for (int i = 0; i < N; i++) begin
        if (in_req_valid[i] && !pre[i] && in_req_tag[i*RW +: RW] != '0) begin
          m_full[i] = 1;
          m_tag[i]  = in_req_tag[i*RW +: RW];
          m_val[i]  = in_req_value[i*DW +: DW];
          m_isj[i]  = in_req_isjump[i];
          m_jad[i]  = in_req_jump_addr[i*DW +: DW];
        end
      end
    end
  endtask

  // One clock: check ready before the edge, then the registered bus after it.
  task automatic cycle();
    #1;
    check("ready", out_req_ready, m_ready());
    @(posedge clk);
    model_edge();
    #1;
    check("cdb_tag", out_cdb_rob_tag, e_tag);
    if (e_chk_payload) begin
      check("cdb_value", out_cdb_value, e_val);
      check("cdb_isjump", out_cdb_isjump, e_isj);
      check("cdb_jump_addr", out_cdb_jump_addr, e_jad);
    end
  endtask

  initial begin
    logic [RW-1:0] exp_seq [6];
    rst = 1'b1; ena = 1'b1; in_flush = 1'b0;
    clear_reqs();
    m_reset();
    #2;
    check("rst_tag", out_cdb_rob_tag, 0);
    check("rst_ready", out_req_ready, 3'b111);
    @(negedge clk);
    rst = 1'b0;

    // Single offer from requester 2: broadcast two edges later, one cycle only.
    set_req(2, 1'b1, 5'd5, 32'h2A, 1'b1, 32'h1000);
    cycle();
    clear_reqs();
    #1;
    check("t1_ready_drop", out_req_ready, 3'b011);
    check("t1_edge1_tag", out_cdb_rob_tag, 0);
    cycle();
    check("t1_edge2_tag", out_cdb_rob_tag, 5);
    check("t1_edge2_value", out_cdb_value, 32'h2A);
    cycle();
    check("t1_edge3_tag", out_cdb_rob_tag, 0);

    // Three full slots with last=2 drain in order 1,2,3.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, RW'(i + 1), DW'(100 + i), 1'b0, 32'h0);
    cycle();
    clear_reqs();
    for (int i = 0; i < N; i++) begin
      cycle();
      check("t2_order", out_cdb_rob_tag, i + 1);
    end

    // Continuous offers of 4,5,6 rotate fairly.
    exp_seq = '{5'd0, 5'd4, 5'd5, 5'd6, 5'd4, 5'd5};
    for (int i = 0; i < N; i++) set_req(i, 1'b1, RW'(i + 4), DW'(200 + i), 1'(i), DW'(300 + i));
    for (int c = 0; c < 6; c++) begin
      cycle();
      check("t2_rr_seq", out_cdb_rob_tag, exp_seq[c]);
    end
    clear_reqs();
    repeat (4) cycle();

    // Zero tag: handshake completes, nothing stored or broadcast.
    set_req(1, 1'b1, 5'd0, 32'hDEAD, 1'b0, 32'h0);
    #1;
    check("t3_ready_hs", out_req_ready[1], 1);
    cycle();
    clear_reqs();
    #1;
    check("t3_slot_empty", out_req_ready, 3'b111);
    repeat (2) begin
      cycle();
      check("t3_no_bcast", out_cdb_rob_tag, 0);
    end

    // Flush drops tags 7 and 9 and refuses a same-cycle offer.
    set_req(0, 1'b1, 5'd7, 32'h7, 1'b0, 32'h0);
    set_req(1, 1'b1, 5'd9, 32'h9, 1'b0, 32'h0);
    cycle();
    clear_reqs();
    in_flush = 1'b1;
    set_req(2, 1'b1, 5'd11, 32'hB, 1'b0, 32'h0);
    #1;
    check("t4_ready_flush", out_req_ready, 3'b000);
    cycle();
    check("t4_flush_tag", out_cdb_rob_tag, 0);
    in_flush = 1'b0;
    clear_reqs();
    repeat (3) begin
      cycle();
      check("t4_dropped", out_cdb_rob_tag, 0);
    end

    // Stall for three cycles while slot 0 holds tag 4.
    set_req(0, 1'b1, 5'd4, 32'h44, 1'b0, 32'h0);
    cycle();
    clear_reqs();
    ena = 1'b0;
    repeat (3) begin
      cycle();
      check("t5_stall_tag", out_cdb_rob_tag, 0);
    end
    ena = 1'b1;
    cycle();
    check("t5_release_tag", out_cdb_rob_tag, 4);
    cycle();
    check("t5_once", out_cdb_rob_tag, 0);

    // Asynchronous reset mid-cycle with full slots and a live broadcast.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, RW'(12 + i), DW'(400 + i), 1'b1, DW'(500 + i));
    cycle();
    clear_reqs();
    cycle();
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    check("t6_rst_tag", out_cdb_rob_tag, 0);
    check("t6_rst_value", out_cdb_value, 0);
    check("t6_rst_jump_addr", out_cdb_jump_addr, 0);
    check("t6_rst_ready", out_req_ready, 3'b111);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      cycle();
      check("t6_no_stale", out_cdb_rob_tag, 0);
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b1, RW'(i + 1), DW'(600 + i), 1'b0, 32'h0);
    cycle();
    clear_reqs();
    for (int i = 0; i < N; i++) begin
      cycle();
      check("t6_prio_order", out_cdb_rob_tag, i + 1);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      ena      = ($urandom_range(0, 9) != 0);
      in_flush = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < N; i++) begin
        set_req(i, 1'($urandom_range(0, 1)), RW'($urandom_range(0, 31)),
                $urandom, 1'($urandom_range(0, 1)), $urandom);
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
